// File: rtl/spi_sclk_gen_if.sv
// Configuration, start and strobe signals of the SPI serial-clock generator.
// The i_abort_n member exists only when SPI_SCLK_ABORT_EN is defined.
interface spi_sclk_gen_if #(
  parameter int unsigned DIV_W = 8,
  parameter int unsigned CNT_W = 6
);
  logic             i_cfg_we;
  logic [DIV_W-1:0] i_half_div;
  logic [CNT_W-1:0] i_nbits;
  logic             i_cpol;
  logic             i_cpha;
  logic             i_start_n;
`ifdef SPI_SCLK_ABORT_EN
  logic             i_abort_n;
`endif
  logic             o_ready;
  logic             o_sclk;
  logic             o_shift;
  logic             o_sample;
  logic [CNT_W:0]   o_bit_count;
  logic             o_done;

  modport master (
    output i_cfg_we, i_half_div, i_nbits, i_cpol, i_cpha, i_start_n,
`ifdef SPI_SCLK_ABORT_EN
    output i_abort_n,
`endif
    input  o_ready, o_sclk, o_shift, o_sample, o_bit_count, o_done
  );

  modport slave (
    input  i_cfg_we, i_half_div, i_nbits, i_cpol, i_cpha, i_start_n,
`ifdef SPI_SCLK_ABORT_EN
    input  i_abort_n,
`endif
    output o_ready, o_sclk, o_shift, o_sample, o_bit_count, o_done
  );
endinterface

// File: rtl/spi_sclk_gen.sv
// Programmable SPI SCLK burst generator with launch/sample strobes for all four modes.
// Optional mid-burst abort input enabled by defining SPI_SCLK_ABORT_EN.
module spi_sclk_gen #(
  parameter int unsigned DIV_W     = 8,
  parameter int unsigned CNT_W     = 6,
  parameter int unsigned RST_NBITS = 8
) (
  input logic           i_clk,
  input logic           i_rst_n,
  spi_sclk_gen_if.slave bus
);

  localparam int unsigned BC_W = CNT_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_TRAIL} state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] half_div_q, half_div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] nbits_q, nbits_d;
  logic             cpol_q, cpol_d;
  logic             cpha_q, cpha_d;
  logic             sclk_q, sclk_d;
  logic             done_q, done_d;
  logic [BC_W-1:0]  bit_count_q, bit_count_d;

  logic             shift_c, sample_c;
  logic             half_hit_c, leading_c, last_trail_c, start_c, abort_c;
  logic [BC_W-1:0]  n_total_c;

  // nbits of zero encodes a full 2^CNT_W burst
  assign n_total_c    = (nbits_q == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, nbits_q};
  assign half_hit_c   = (cnt_q == half_div_q);
  assign leading_c    = (sclk_q == cpol_q);
  assign last_trail_c = !leading_c && ((bit_count_q + BC_W'(1)) == n_total_c);
  // A held start is not honoured in the done cycle, leaving one idle cycle between bursts
  assign start_c      = !bus.i_cfg_we && !bus.i_start_n && !done_q;

`ifdef SPI_SCLK_ABORT_EN
  assign abort_c = (state_q != S_IDLE) && !bus.i_abort_n;
`else
  assign abort_c = 1'b0;
`endif

  // State and datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      half_div_q  <= '0;
      cnt_q       <= '0;
      nbits_q     <= CNT_W'(RST_NBITS);
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      sclk_q      <= 1'b0;
      done_q      <= 1'b0;
      bit_count_q <= '0;
    end else begin
      state_q     <= state_d;
      half_div_q  <= half_div_d;
      cnt_q       <= cnt_d;
      nbits_q     <= nbits_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      sclk_q      <= sclk_d;
      done_q      <= done_d;
      bit_count_q <= bit_count_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_c) state_d = S_RUN;
      S_RUN:   if (half_hit_c && last_trail_c) state_d = S_TRAIL;
      S_TRAIL: if (half_hit_c) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_c) state_d = S_IDLE;
  end

  // Datapath next values and edge strobes
  always_comb begin
    half_div_d  = half_div_q;
    nbits_d     = nbits_q;
    cpol_d      = cpol_q;
    cpha_d      = cpha_q;
    cnt_d       = cnt_q;
    sclk_d      = sclk_q;
    bit_count_d = bit_count_q;
    done_d      = 1'b0;
    shift_c     = 1'b0;
    sample_c    = 1'b0;
    case (state_q)
      S_IDLE: begin
        sclk_d = cpol_q;
        if (bus.i_cfg_we) begin
          half_div_d = bus.i_half_div;
          nbits_d    = bus.i_nbits;
          cpol_d     = bus.i_cpol;
          cpha_d     = bus.i_cpha;
          sclk_d     = bus.i_cpol;
        end else if (start_c) begin
          cnt_d       = '0;
          bit_count_d = '0;
          shift_c     = !cpha_q;
        end
      end
      S_RUN: begin
        if (half_hit_c) begin
          cnt_d  = '0;
          sclk_d = !sclk_q;
          if (leading_c) begin
            shift_c  = cpha_q;
            sample_c = !cpha_q;
          end else begin
            bit_count_d = bit_count_q + BC_W'(1);
            sample_c    = cpha_q;
            shift_c     = !cpha_q && !last_trail_c;
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      S_TRAIL: begin
        if (half_hit_c) begin
          cnt_d  = '0;
          done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
    // Abort keeps the partial bit count and reports completion next cycle
    if (abort_c) begin
      sclk_d      = cpol_q;
      cnt_d       = '0;
      bit_count_d = bit_count_q;
      done_d      = 1'b1;
      shift_c     = 1'b0;
      sample_c    = 1'b0;
    end
  end

  assign bus.o_ready     = (state_q == S_IDLE);
  assign bus.o_sclk      = sclk_q;
  assign bus.o_shift     = shift_c;
  assign bus.o_sample    = sample_c;
  assign bus.o_bit_count = bit_count_q;
  assign bus.o_done      = done_q;

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Randomised bench for spi_sclk_gen against a closed-form burst waveform model.
// Covers the abort path when SPI_SCLK_ABORT_EN is defined.
module tb_spi_sclk_gen;

  localparam int unsigned DIV_W = 8;
  localparam int unsigned CNT_W = 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;

  spi_sclk_gen_if #(.DIV_W(DIV_W), .CNT_W(CNT_W)) bus ();

  spi_sclk_gen #(.DIV_W(DIV_W), .CNT_W(CNT_W), .RST_NBITS(8)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
    $fatal(1);
  end

  // model: current config, and the config captured by the active/last burst
  int m_cpol, m_cpha, m_h, m_n;
  int b_cpol, b_cpha, b_h, b_n;
  int m_start, m_end, m_abort, m_prev_bc, m_last_bc;
  bit chk_en = 1'b0;

  // burst statistics gathered by the compare process
  int   s_shift, s_sample, s_done, s_first_edge, s_done_off;
  logic prev_sclk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_checks++;
    if (act !== 32'(exp)) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int bc_at(input int off);
    int tv;
    tv = (off - 1) / b_h;
    if (tv > 2 * b_n) tv = 2 * b_n;
    return tv / 2;
  endfunction

  // Expected outputs for cycle c from start offset, half-period and burst length
  function automatic void model(input int c, output int e_rdy, output int e_sclk,
                                output int e_shift, output int e_sample,
                                output int e_bc, output int e_done);
    int off, tv, k;
    e_rdy = 1; e_sclk = m_cpol; e_shift = 0; e_sample = 0; e_bc = m_last_bc; e_done = 0;
    if (m_start < 0) return;
    if (c >= m_end) begin
      e_done = (c == m_end) ? 1 : 0;
      return;
    end
    off = c - m_start;
    if (off == 0) begin
      e_sclk  = b_cpol;
      e_shift = (b_cpha == 0) ? 1 : 0;
      e_bc    = m_prev_bc;
      return;
    end
    e_rdy  = 0;
    tv     = (off - 1) / b_h;
    if (tv > 2 * b_n) tv = 2 * b_n;
    e_sclk = b_cpol ^ (tv % 2);
    e_bc   = tv / 2;
    if ((off % b_h) == 0 && (off / b_h) <= 2 * b_n && c != m_abort) begin
      k = off / b_h;
      if (k % 2 == 1) begin
        if (b_cpha != 0) e_shift = 1; else e_sample = 1;
      end else begin
        if (b_cpha != 0) e_sample = 1;
        else if (k != 2 * b_n) e_shift = 1;
      end
    end
  endfunction

  task automatic compare_loop();
    int e_rdy, e_sclk, e_shift, e_sample, e_bc, e_done;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        model(cyc, e_rdy, e_sclk, e_shift, e_sample, e_bc, e_done);
        chk("o_ready",     32'(bus.o_ready),     e_rdy);
        chk("o_sclk",      32'(bus.o_sclk),      e_sclk);
        chk("o_shift",     32'(bus.o_shift),     e_shift);
        chk("o_sample",    32'(bus.o_sample),    e_sample);
        chk("o_bit_count", 32'(bus.o_bit_count), e_bc);
        chk("o_done",      32'(bus.o_done),      e_done);
        if (cyc == m_start) begin
          s_shift = 0; s_sample = 0; s_done = 0; s_first_edge = -1; s_done_off = -1;
        end else if (m_start >= 0 && s_first_edge < 0 && bus.o_sclk !== prev_sclk) begin
          s_first_edge = cyc - m_start;
        end
        if (bus.o_shift === 1'b1)  s_shift++;
        if (bus.o_sample === 1'b1) s_sample++;
        if (bus.o_done === 1'b1) begin
          s_done++;
          s_done_off = cyc - m_start;
        end
        prev_sclk = bus.o_sclk;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_cpol = 0; m_cpha = 0; m_h = 1; m_n = 8;
    m_start = -1; m_end = -1; m_abort = -1; m_prev_bc = 0; m_last_bc = 0;
  endtask

  task automatic do_cfg(input int hd, input int nb, input int cpol, input int cpha, input bit tie);
    bus.i_cfg_we   = 1'b1;
    bus.i_half_div = DIV_W'(hd);
    bus.i_nbits    = CNT_W'(nb);
    bus.i_cpol     = 1'(cpol);
    bus.i_cpha     = 1'(cpha);
    bus.i_start_n  = tie ? 1'b0 : 1'b1;
    tick();
    bus.i_cfg_we  = 1'b0;
    bus.i_start_n = 1'b1;
    m_h = hd + 1; m_n = (nb == 0) ? 64 : nb; m_cpol = cpol; m_cpha = cpha;
  endtask

  task automatic start_burst();
    bus.i_cfg_we  = 1'b0;
    bus.i_start_n = 1'b0;
    b_cpol = m_cpol; b_cpha = m_cpha; b_h = m_h; b_n = m_n;
    m_prev_bc = m_last_bc;
    m_last_bc = b_n;
    m_start   = cyc;
    m_abort   = -1;
    m_end     = cyc + 2 * b_n * b_h + b_h + 1;
  endtask

  // Runs one burst with random noise on ignored inputs; returns in the cycle after o_done
  task automatic run_burst(input int abort_off, input bit hold);
    start_burst();
    if (abort_off > 0) begin
      m_abort   = m_start + abort_off;
      m_end     = m_abort + 1;
      m_last_bc = bc_at(abort_off);
    end
    forever begin
      tick();
      if (cyc >= m_end) break;
      bus.i_cfg_we   = 1'($urandom);
      bus.i_half_div = DIV_W'($urandom);
      bus.i_nbits    = CNT_W'($urandom);
      bus.i_cpol     = 1'($urandom);
      bus.i_cpha     = 1'($urandom);
      bus.i_start_n  = hold ? 1'b0 : 1'($urandom);
`ifdef SPI_SCLK_ABORT_EN
      bus.i_abort_n  = (cyc == m_abort) ? 1'b0 : 1'b1;
`endif
    end
    bus.i_cfg_we  = 1'b0;
    bus.i_start_n = hold ? 1'b0 : 1'($urandom);
`ifdef SPI_SCLK_ABORT_EN
    bus.i_abort_n = 1'b1;
`endif
    tick();
    if (!hold) bus.i_start_n = 1'b1;
  endtask

  initial begin
    int hd, nb, abort_off;
    bus.i_cfg_we   = 1'b0;
    bus.i_half_div = '0;
    bus.i_nbits    = '0;
    bus.i_cpol     = 1'b0;
    bus.i_cpha     = 1'b0;
    bus.i_start_n  = 1'b1;
`ifdef SPI_SCLK_ABORT_EN
    bus.i_abort_n  = 1'b1;
`endif
    model_reset();
    s_shift = 0; s_sample = 0; s_done = 0; s_first_edge = -1; s_done_off = -1;
    prev_sclk = 1'b0;
    fork
      compare_loop();
    join_none

    rst_n = 1'b0;
    repeat (3) tick();
    chk("reset_sclk",  32'(bus.o_sclk), 0);
    chk("reset_ready", 32'(bus.o_ready), 1);
    chk("reset_bc",    32'(bus.o_bit_count), 0);
    chk("reset_done",  32'(bus.o_done), 0);
    chk("reset_shift", 32'(bus.o_shift), 0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    repeat (2) tick();

    // reset defaults: half_div=0, N=8, mode 0
    run_burst(0, 1'b0);
    chk("t1_shift",    32'(s_shift), 8);
    chk("t1_sample",   32'(s_sample), 8);
    chk("t1_done_cnt", 32'(s_done), 1);
    chk("t1_done_off", 32'(s_done_off), 18);
    chk("t1_bc",       32'(bus.o_bit_count), 8);

    // mode 3, half_div=3, N=5
    do_cfg(3, 5, 1, 1, 1'b0);
    tick();
    run_burst(0, 1'b0);
    chk("t2_first_edge", 32'(s_first_edge), 5);
    chk("t2_shift",      32'(s_shift), 5);
    chk("t2_sample",     32'(s_sample), 5);
    chk("t2_done_cnt",   32'(s_done), 1);
    chk("t2_done_off",   32'(s_done_off), 45);
    chk("t2_idle_sclk",  32'(bus.o_sclk), 1);

    // nbits=0 -> 64 SCLK cycles
    do_cfg(0, 0, 0, 0, 1'b0);
    run_burst(0, 1'b0);
    chk("t3_bc",       32'(bus.o_bit_count), 64);
    chk("t3_sample",   32'(s_sample), 64);
    chk("t3_shift",    32'(s_shift), 64);
    chk("t3_done_off", 32'(s_done_off), 130);

    // config and start in the same cycle: config wins, start next cycle
    do_cfg(1, 3, 0, 1, 1'b1);
    chk("tie_ready", 32'(bus.o_ready), 1);
    run_burst(0, 1'b0);
    chk("tie_first_edge", 32'(s_first_edge), 3);
    chk("tie_shift",      32'(s_shift), 3);
    chk("tie_sample",     32'(s_sample), 3);
    chk("tie_bc",         32'(bus.o_bit_count), 3);

    // start held low: bursts re-arm one cycle after o_done
    do_cfg(0, 2, 1, 0, 1'b0);
    run_burst(0, 1'b1);
    run_burst(0, 1'b1);
    run_burst(0, 1'b0);
    chk("hold_done_off", 32'(s_done_off), 6);
    chk("hold_bc",       32'(bus.o_bit_count), 2);

`ifdef SPI_SCLK_ABORT_EN
    // abort after 3 SCLK cycles, on a leading-edge toggle cycle
    do_cfg(1, 8, 1, 0, 1'b0);
    run_burst(14, 1'b0);
    chk("abort_bc",       32'(bus.o_bit_count), 3);
    chk("abort_done_cnt", 32'(s_done), 1);
    chk("abort_done_off", 32'(s_done_off), 15);
    chk("abort_sclk",     32'(bus.o_sclk), 1);
    chk("abort_sample",   32'(s_sample), 3);
`endif

    // asynchronous reset in the middle of a cpol=1 burst
    do_cfg(2, 10, 1, 0, 1'b0);
    start_burst();
    tick();
    bus.i_start_n = 1'b1;
    repeat (7) tick();
    chk("mid_sclk_pre", 32'(bus.o_sclk), 1);
    chk("mid_bc_pre",   32'(bus.o_bit_count), 1);
    chk_en = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sclk",  32'(bus.o_sclk), 0);
    chk("mid_rst_ready", 32'(bus.o_ready), 1);
    chk("mid_rst_bc",    32'(bus.o_bit_count), 0);
    chk("mid_rst_done",  32'(bus.o_done), 0);
    model_reset();
    repeat (3) begin
      @(negedge clk);
      chk("mid_rst_hold_done", 32'(bus.o_done), 0);
    end
    tick();
    rst_n  = 1'b1;
    chk_en = 1'b1;
    repeat (2) tick();
    run_burst(0, 1'b0);
    chk("post_rst_done_off", 32'(s_done_off), 18);

    // randomised bursts
    for (int i = 0; i < 24; i++) begin
      if (i == 0) begin
        hd = 255; nb = 1;
      end else begin
        hd = int'($urandom_range(0, 4));
        nb = int'($urandom_range(0, 63));
      end
      do_cfg(hd, nb, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), 1'b0);
      repeat ($urandom_range(0, 3)) tick();
      abort_off = 0;
`ifdef SPI_SCLK_ABORT_EN
      if ($urandom_range(0, 2) == 0) abort_off = int'($urandom_range(1, 2 * m_n * m_h + m_h));
`endif
      run_burst(abort_off, 1'b0);
      chk("rand_done_cnt", 32'(s_done), 1);
    end

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_sclk_gen.md
Name: spi_sclk_gen

Overview:
Parametrised SPI serial-clock generator, successor to the fixed 8-cycle divider in the SPI controller. It produces a programmable-length burst of SCLK cycles from the system clock. Divisor width, burst length, CPOL and CPHA are all run-time configurable. It emits single-cycle launch/sample strobes so the shift register stays in the i_clk domain for all four SPI modes.

Parameters:
DIV_W, 8, width of half-period divisor; SCLK half-period = i_half_div+1 i_clk cycles
CNT_W, 6, width of burst-length field and bit counter
RST_NBITS, 8, burst length after reset; must fit in CNT_W bits

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  reset; one clock; reset is asynchronous and active-low
i_cfg_we  in  1  latch configuration inputs (honoured in IDLE only)
i_half_div  in  DIV_W  half-period minus one
i_nbits  in  CNT_W  SCLK cycles per burst; 0 means 2^CNT_W
i_cpol  in  1  SCLK idle level
i_cpha  in  1  0: sample on leading edge; 1: sample on trailing edge
i_start_n  in  1  active-low start request
o_ready  out  1  high in IDLE
o_sclk  out  1  registered serial clock
o_shift  out  1  one-cycle launch strobe
o_sample  out  1  one-cycle sample strobe
o_bit_count  out  CNT_W+1  completed SCLK cycles in the current burst
o_done  out  1  one-cycle end-of-burst pulse

Behaviour:
- Reset state: IDLE, o_sclk=0, cpol=0, cpha=0, half_div=0, nbits=RST_NBITS, o_bit_count=0, o_done=0, strobes=0, fast counter=0.
- States are IDLE, RUN and TRAIL.
- IDLE, cfg path: if i_cfg_we=1, register i_half_div, i_nbits, i_cpol and i_cpha. i_start_n is ignored that cycle, so config wins on a tie. o_sclk equals the new cpol from the next cycle.
- IDLE, start path: if i_cfg_we=0 and i_start_n=0 in cycle T:
  - go to RUN, clear the fast counter and o_bit_count.
  - if cpha=0, o_shift=1 in cycle T (first bit launch).
- RUN, counting: the fast counter increments each cycle. When it equals half_div, it clears and o_sclk toggles (registered). The first toggle therefore appears at T+2+half_div.
- RUN, toggle cycle strobes: in the cycle the toggle is decided, o_shift/o_sample are combinational. Leading edge = toggle away from cpol; trailing edge = toggle back to cpol.
  - cpha=0: leading edge gives o_sample; trailing edge gives o_shift, except the final trailing edge.
  - cpha=1: leading edge gives o_shift; trailing edge gives o_sample.
- RUN, bit count: o_bit_count increments on each trailing-edge toggle.
- RUN to TRAIL: after the 2*N-th toggle (N = nbits, 0 means 2^CNT_W), go to TRAIL with o_sclk=cpol.
- TRAIL: hold for half_div+1 cycles (CS hold time), then go to IDLE.
- o_done: registered, high for exactly the first IDLE cycle after TRAIL. o_bit_count holds N until the next start.
- Busy inputs: i_cfg_we and i_start_n are ignored in RUN and TRAIL. i_start_n held low continuously re-arms only after o_done, with at least one IDLE cycle between bursts.
- Widths: the fast counter is DIV_W bits and never wraps past half_div. half_div=0 gives f/2 SCLK. All-ones gives f/2^(DIV_W+1).
- Reset mid-burst: asynchronous return to reset values. o_sclk goes to 0 regardless of cpol, and no o_done is issued.

Optional Feature:
Macro SPI_SCLK_ABORT_EN.
- Defined: adds input i_abort_n (active-low). In RUN or TRAIL, i_abort_n=0 forces the next state to IDLE, o_sclk=cpol, fast counter cleared and strobes suppressed that cycle. o_done pulses the next cycle, and o_bit_count retains the partial count.
- Undefined: port absent; bursts always complete.

Test Plan:
- Reset, no config; start with defaults (half_div=0, N=8, mode 0) -> 16 toggles, o_sclk period 2 clocks, 8 o_sample, 7 o_shift after the start-cycle o_shift, o_bit_count=8, o_done one cycle after 1-cycle TRAIL.
- cfg half_div=3, N=5, cpol=1, cpha=1; start -> o_sclk idles 1, first falling edge at T+5, half-period 4 clocks, 5 o_shift on falling edges, 5 o_sample on rising edges, o_done once.
- i_nbits=0 with CNT_W=6 -> 64 SCLK cycles, o_bit_count=64.
- i_cfg_we and i_start_n low in the same IDLE cycle -> config latched, no burst; start next cycle -> burst uses the new config.
- Assert i_rst_n=0 asynchronously mid-RUN with cpol=1 -> o_sclk=0, o_ready=1 and o_bit_count=0 immediately, no o_done.
- With SPI_SCLK_ABORT_EN: abort after 3 SCLK cycles -> IDLE next cycle, o_sclk=cpol, o_bit_count=3, single o_done pulse.
